// File: rtl/cpu_ctrl_defs.sv
// rtl/cpu_ctrl_defs.sv - mode encodings shared by the step controller and the display block
package cpu_ctrl_defs;

    localparam logic [1:0] MODE_PAUSE = 2'b00;
    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_HALT  = 2'b11;

    typedef enum logic [1:0] {
        ST_PAUSE = MODE_PAUSE,
        ST_RUN   = MODE_RUN,
        ST_STEP  = MODE_STEP,
        ST_HALT  = MODE_HALT
    } mode_e;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchroniser, tick-qualified debounce and press pulse
module btn_debounce #(
    parameter int unsigned DEB_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    output logic press_o
);

    localparam logic [3:0] DEB_LIMIT = 4'(DEB_TICKS);

    logic       meta_q;
    logic       sync_q;
    logic       level_q;
    logic       level_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       press_q;
    logic       press_d;

    // The counter only advances on slow ticks, so a level must survive DEB_TICKS slow periods.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (tick_i) begin
            if (sync_q != level_q) begin
                if (cnt_q + 4'd1 == DEB_LIMIT) begin
                    level_d = sync_q;
                    cnt_d   = 4'd0;
                    press_d = sync_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 4'd0;
            press_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - pause / run / single-step clock-enable generator for the multi-cycle CPU
module cpu_step_ctrl
    import cpu_ctrl_defs::*;
#(
    parameter int unsigned DEB_TICKS = 2,
    parameter bit          RUN_SLOW  = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_pause,
    input  logic             cpu_halted,
    output logic             tick,
    output logic             cpu_en,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] step_count
);

    logic             slow_in_q;
    logic             slow_q;
    logic             p_run;
    logic             p_step;
    logic             p_pause;
    mode_e            state_q;
    mode_e            state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // slow_clk is registered once before edge detection so tick depends on flops only.
    assign tick = slow_in_q & ~slow_q;

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_run (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .btn_i   (btn_run),
        .press_o (p_run)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_step (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .btn_i   (btn_step),
        .press_o (p_step)
    );

    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_pause (
        .clk     (clk),
        .reset   (reset),
        .tick_i  (tick),
        .btn_i   (btn_pause),
        .press_o (p_pause)
    );

    always_comb begin
        state_d = state_q;
        cpu_en  = 1'b0;
        case (state_q)
            ST_PAUSE: begin
                if (p_pause) begin
                    state_d = ST_PAUSE;
                end else if (p_step) begin
                    state_d = ST_STEP;
                end else if (p_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_d = ST_PAUSE;
            end
            ST_RUN: begin
                cpu_en = RUN_SLOW ? tick : 1'b1;
                if (p_pause || p_step) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_PAUSE;
        endcase
        // A halt wins over every button; the enable of the current cycle still goes out.
        if (cpu_halted) begin
            state_d = ST_HALT;
        end
    end

    always_comb begin
        count_d = count_q;
        if (cpu_en && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slow_in_q <= 1'b0;
            slow_q    <= 1'b0;
            state_q   <= ST_PAUSE;
            count_q   <= '0;
        end else begin
            slow_in_q <= slow_clk;
            slow_q    <= slow_in_q;
            state_q   <= state_d;
            count_q   <= count_d;
        end
    end

    assign mode       = state_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb/tb_cpu_step_ctrl.sv - self-checking bench for cpu_step_ctrl (three parameterisations, shared stimulus)
module tb_cpu_step_ctrl;

    localparam int DEB = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic slow_clk = 1'b0;
    logic btn_run = 1'b0;
    logic btn_step = 1'b0;
    logic btn_pause = 1'b0;
    logic cpu_halted = 1'b0;

    logic        tick0, tick1, tick2;
    logic        en0, en1, en2;
    logic [1:0]  mode0, mode1, mode2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.DEB_TICKS(DEB), .RUN_SLOW(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .cpu_halted(cpu_halted), .tick(tick0), .cpu_en(en0),
        .mode(mode0), .step_count(cnt0));

    cpu_step_ctrl #(.DEB_TICKS(DEB), .RUN_SLOW(1'b1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .cpu_halted(cpu_halted), .tick(tick1), .cpu_en(en1),
        .mode(mode1), .step_count(cnt1));

    cpu_step_ctrl #(.DEB_TICKS(DEB), .RUN_SLOW(1'b0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .slow_clk(slow_clk), .btn_run(btn_run), .btn_step(btn_step),
        .btn_pause(btn_pause), .cpu_halted(cpu_halted), .tick(tick2), .cpu_en(en2),
        .mode(mode2), .step_count(cnt2));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // slow clock: toggles every 4 clk, driven just after the rising edge
    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #1 slow_clk = ~slow_clk;
        end
    end

    // Behavioural model: sampled input history, debounce run-lengths, mode and per-instance counts
    int m_s1 = 0, m_s0 = 0;
    int m_sy1[3] = '{0, 0, 0};
    int m_sy2[3] = '{0, 0, 0};
    int m_acc[3] = '{0, 0, 0};
    int m_cnt[3] = '{0, 0, 0};
    int m_press[3] = '{0, 0, 0};
    int m_mode = 0;
    int m_count[3] = '{0, 0, 0};
    int m_max[3] = '{65535, 65535, 15};
    int m_bt[3];
    int m_tk, m_np;

    function automatic int m_tick();
        return (m_s1 == 1 && m_s0 == 0) ? 1 : 0;
    endfunction

    function automatic int m_en(input int i);
        if (m_mode == 2) return 1;
        if (m_mode == 1) return (i == 1) ? m_tick() : 1;
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_s1 = 0; m_s0 = 0; m_mode = 0;
                for (int i = 0; i < 3; i++) begin
                    m_sy1[i] = 0; m_sy2[i] = 0; m_acc[i] = 0; m_cnt[i] = 0;
                    m_press[i] = 0; m_count[i] = 0;
                end
            end else begin
                m_tk = m_tick();
                for (int i = 0; i < 3; i++)
                    if (m_en(i) == 1 && m_count[i] < m_max[i]) m_count[i]++;
                if (cpu_halted) m_mode = 3;
                else if (m_mode == 0) begin
                    if (m_press[2] == 1) m_mode = 0;
                    else if (m_press[1] == 1) m_mode = 2;
                    else if (m_press[0] == 1) m_mode = 1;
                end else if (m_mode == 1) begin
                    if (m_press[2] == 1 || m_press[1] == 1) m_mode = 0;
                end else if (m_mode == 2) m_mode = 0;
                m_bt = '{int'(btn_run), int'(btn_step), int'(btn_pause)};
                for (int i = 0; i < 3; i++) begin
                    m_np = 0;
                    if (m_tk == 1) begin
                        if (m_sy2[i] != m_acc[i]) begin
                            m_cnt[i]++;
                            if (m_cnt[i] == DEB) begin
                                m_acc[i] = m_sy2[i];
                                m_cnt[i] = 0;
                                m_np = m_acc[i];
                            end
                        end else m_cnt[i] = 0;
                    end
                    m_press[i] = m_np;
                    m_sy2[i] = m_sy1[i];
                    m_sy1[i] = m_bt[i];
                end
                m_s0 = m_s1;
                m_s1 = int'(slow_clk);
            end
        end
    end

    // Per-cycle compare plus observation counters used by the directed checks
    int chk_en = 0;
    int cyc = 0, last_tick = -2, n_ticks = 0;
    int en_cnt0 = 0, en_cnt1 = 0, step_seen = 0, run_cyc = 0, win = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en == 1) begin
                chk("tick0", int'(tick0), m_tick());
                chk("tick1", int'(tick1), m_tick());
                chk("tick2", int'(tick2), m_tick());
                chk("cpu_en0", int'(en0), m_en(0));
                chk("cpu_en1", int'(en1), m_en(1));
                chk("cpu_en2", int'(en2), m_en(2));
                chk("mode0", int'(mode0), m_mode);
                chk("mode1", int'(mode1), m_mode);
                chk("mode2", int'(mode2), m_mode);
                chk("count0", int'(cnt0), m_count[0]);
                chk("count1", int'(cnt1), m_count[1]);
                chk("count2", int'(cnt2), m_count[2]);
                if (!reset) last_tick = -2;
                else if (tick0) begin
                    n_ticks++;
                    if (last_tick >= 0) chk("tick_period", cyc - last_tick, 8);
                    last_tick = (last_tick == -2) ? -1 : cyc;
                end
                if (en0) en_cnt0++;
                if (mode0 == 2'd2) step_seen = 1;
                if (m_mode == 1) run_cyc++;
                if (win == 1 && en1) begin
                    en_cnt1++;
                    chk("slow_en_with_tick", int'(tick1), 1);
                end
            end
            cyc++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_mode(input int m, input int limit, input string name);
        int k = 0;
        while (int'(mode0) != m && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, int'(mode0), m);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_tick"}, int'(tick0), 0);
        chk({name, "_en0"}, int'(en0), 0);
        chk({name, "_en1"}, int'(en1), 0);
        chk({name, "_mode"}, int'(mode0), 0);
        chk({name, "_cnt0"}, int'(cnt0), 0);
        chk({name, "_cnt2"}, int'(cnt2), 0);
    endtask

    initial begin
        int k;
        // 1: reset state, then idle with ticks every 8 clk
        clks(3);
        chk_en = 1;
        chk_all_zero("rst");
        n_ticks = 0;
        reset = 1'b1;
        clks(40);
        chk("t1_ticks_in_40", n_ticks, 5);
        chk("t1_mode", int'(mode0), 0);
        chk("t1_cnt", int'(cnt0), 0);

        // 2: held step button gives one enable; a one-clk glitch gives none
        en_cnt0 = 0;
        step_seen = 0;
        btn_step = 1'b1;
        clks(30);
        btn_step = 1'b0;
        clks(40);
        chk("t2_pulses", en_cnt0, 1);
        chk("t2_step_seen", step_seen, 1);
        chk("t2_cnt", int'(cnt0), 1);
        chk("t2_mode", int'(mode0), 0);
        k = 0;
        while (!tick0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t2_tick_wait", int'(tick0), 1);
        @(posedge clk); #1 btn_step = 1'b1;
        @(posedge clk); #1 btn_step = 1'b0;
        clks(40);
        chk("t2_glitch_cnt", int'(cnt0), 1);
        chk("t2_glitch_mode", int'(mode0), 0);

        // 3/4: run, slow-run window of 64 clk, then pause
        run_cyc = 0;
        btn_run = 1'b1;
        wait_mode(1, 40, "t3_enter_run");
        clks(8);
        en_cnt1 = 0;
        win = 1;
        clks(64);
        win = 0;
        chk("t4_slow_pulses", en_cnt1, 8);
        clks(10);
        btn_run = 1'b0;
        btn_pause = 1'b1;
        wait_mode(0, 40, "t3_back_to_pause");
        clks(10);
        btn_pause = 1'b0;
        clks(30);
        chk("t3_run_len_sane", (run_cyc >= 90 && run_cyc <= 110) ? 1 : 0, 1);
        chk("t3_cnt", int'(cnt0), 1 + run_cyc);
        chk("t3_sat4", int'(cnt2), 15);
        chk("t3_mode", int'(mode0), 0);

        // 5: halt from run, buttons ignored afterwards
        btn_run = 1'b1;
        wait_mode(1, 40, "t5_enter_run");
        btn_run = 1'b0;
        clks(10);
        cpu_halted = 1'b1;
        @(negedge clk);
        chk("t5_en_halt_cycle", int'(en0), 1);
        chk("t5_mode_halt_cycle", int'(mode0), 1);
        @(negedge clk);
        chk("t5_mode_halt", int'(mode0), 3);
        chk("t5_en_after", int'(en0), 0);
        clks(1);
        cpu_halted = 1'b0;
        k = int'(cnt0);
        btn_step = 1'b1;
        clks(30);
        btn_step = 1'b0;
        btn_run = 1'b1;
        clks(30);
        btn_run = 1'b0;
        clks(20);
        chk("t5_still_halt", int'(mode0), 3);
        chk("t5_cnt_frozen", int'(cnt0), k);

        // 6: reset leaves halt; reset mid-run clears everything asynchronously
        reset = 1'b0;
        #2;
        chk_all_zero("t6_rst_halt");
        clks(2);
        reset = 1'b1;
        btn_run = 1'b1;
        wait_mode(1, 40, "t6_enter_run");
        clks(20);
        chk("t6_sat4", int'(cnt2), 15);
        #2 reset = 1'b0;
        #1;
        chk_all_zero("t6_rst_mid");
        clks(3);
        btn_run = 1'b0;
        reset = 1'b1;
        clks(20);
        chk("t6_post_mode", int'(mode0), 0);
        chk("t6_post_cnt", int'(cnt0), 0);
        chk("t6_post_en", int'(en0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
